merge4_rr_arb: RTL and testbench
================================

MERGE4_RR_ARB -- requirements
Module: merge4_rr_arb

Interface
REQ-001 Parameter DATA_W, default 2, SHALL set the packet field width (type field).
REQ-002 Parameter CW, default 4, SHALL set the per-input wait-counter width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset, synchronous and active-low (rst==0 resets).
REQ-005 Ports i0..i3$irdy, input, 1 each, SHALL be the requester-valid signals.
REQ-006 Ports i0..i3$trdy, output, 1 each, SHALL be the per-input accept signals.
REQ-007 Ports i0..i3$data$type, input, DATA_W each, SHALL be the requester payloads.
REQ-008 Port o0$irdy, output, 1, SHALL be the merged-output valid.
REQ-009 Port o0$trdy, input, 1, SHALL be the downstream accept.
REQ-010 Port o0$data$type, output, DATA_W, SHALL be the payload of the selected input.
REQ-011 Port sel, output, 2, SHALL be the index of the currently selected input.
REQ-012 Port starve, output, 4, SHALL flag inputs whose wait counter is saturated.
REQ-013 Port xfer_cnt, output, 16, SHALL count completed output transfers.

Function
REQ-014 o0$irdy SHALL equal OR of i0..i3$irdy when rst==1, and 0 when rst==0.
REQ-015 When lock==0, sel SHALL be the first asserted irdy searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); sel SHALL be ptr when no irdy is asserted.
REQ-016 When lock==1, sel SHALL equal lock_idx regardless of other irdy inputs.
REQ-017 ik$trdy SHALL equal (sel==k) && ik$irdy && o0$trdy && rst; at most one trdy is high per cycle.
REQ-018 o0$data$type SHALL equal data of input sel, combinationally, with zero-cycle latency.
REQ-019 Transfer (o0$irdy && o0$trdy) SHALL set ptr <= sel+1 mod 4 and lock <= 0 next cycle.
REQ-020 Stall (o0$irdy && !o0$trdy) SHALL set lock <= 1 and lock_idx <= sel, so the output packet stays stable until accepted.
REQ-021 If a locked input drops irdy (protocol violation), lock SHALL clear next cycle; no trdy is issued for it.
REQ-022 Wait counter k SHALL increment, saturating at 2^CW-1, in each cycle where ik$irdy && !ik$trdy; it SHALL clear when ik$trdy==1 or ik$irdy==0.
REQ-023 starve[k] SHALL be 1 exactly when wait counter k equals 2^CW-1.
REQ-024 xfer_cnt SHALL increment by 1 per transfer, wrapping 0xFFFF -> 0x0000.
REQ-025 With all four inputs persistently valid and o0$trdy==1, grants SHALL rotate 0,1,2,3,0,... one per cycle; any valid input SHALL be served within 3 other transfers.
REQ-026 A transfer and new irdy in the same cycle SHALL be arbitrated next cycle using the updated ptr.

Reset
REQ-027 While rst==0: all trdy=0, o0$irdy=0, and next edge sets ptr=0, lock=0, lock_idx=0, wait counters=0, xfer_cnt=0.
REQ-028 Reset mid-stall SHALL discard the lock; the stalled packet is not counted as transferred.
REQ-029 sel SHALL read 0 and starve SHALL read 0 during and in the first cycle after reset.

Structure
REQ-030 Shared package merge_arb_pkg SHALL hold N_IN=4, DATA_W default, and type constants TYPE_REQ=0, TYPE_RSP=1.
REQ-031 The rotate-priority search SHALL be a combinational sub-module rr_pick4 (inputs: 4-bit req, 2-bit ptr; outputs: 2-bit idx, any).
REQ-032 State SHALL be limited to ptr, lock, lock_idx, four CW-bit counters and xfer_cnt.

Verification
REQ-033 All irdy=1, types 0,1,2,3, o0$trdy=1 for 8 cycles -> sel 0,1,2,3,0,1,2,3; xfer_cnt=8.
REQ-034 i2 only valid, o0$trdy=0 for 3 cycles, i0 raised at cycle 1 -> sel stays 2, data stays i2's; trdy to i2 on the cycle o0$trdy=1; ptr=3.
REQ-035 i1 valid, o0$trdy=0 for 20 cycles, CW=4 -> starve[1]=1 from cycle 15; clears the cycle after i1 transfers.
REQ-036 Stall locked on i3, rst=0 for one cycle -> next cycle lock=0, ptr=0, xfer_cnt=0, all trdy=0 during reset.
REQ-037 xfer_cnt preloaded near 0xFFFF via 65535 transfers, then one more -> xfer_cnt=0x0000.
REQ-038 Random irdy/o0$trdy, 10k cycles -> never more than one trdy, locked data stable, no input waits more than 3 transfers while persistently valid.

Source files
------------

// File: rtl/merge4_rr_arb_pkg.sv
// Shared constants for the 4-input round-robin merge arbiter.
//   N_IN       : number of requester inputs
//   DEF_DATA_W : default width of the packet type field
//   TYPE_REQ / TYPE_RSP : packet type encodings carried on the data field
package merge_arb_pkg;
  localparam int N_IN       = 4;
  localparam int DEF_DATA_W = 2;

  localparam logic [DEF_DATA_W-1:0] TYPE_REQ = DEF_DATA_W'(0);
  localparam logic [DEF_DATA_W-1:0] TYPE_RSP = DEF_DATA_W'(1);
endpackage

// File: rtl/merge4_rr_arb_rr_pick4.sv
// Combinational rotate-priority search over four requests.
//   i_req : request vector, bit k = input k requesting
//   i_ptr : index that has highest priority this cycle
//   o_idx : first requesting index at or after i_ptr (mod 4); i_ptr if none
//   o_any : at least one request present
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_idx,
  output logic       o_any
);

  logic [1:0] w_cand;

  // Walk from the farthest candidate back to i_ptr so the nearest one wins.
  always_comb begin
    o_idx  = i_ptr;
    o_any  = |i_req;
    w_cand = i_ptr;
    for (int d = 3; d >= 0; d--) begin
      w_cand = i_ptr + 2'(d);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/merge4_rr_arb.sv
// Four-into-one valid/ready merge with round-robin arbitration.
// A stalled output locks onto its selected input so the presented packet
// stays stable until accepted.
//   clk, rst            : clock, synchronous active-low reset
//   iN_irdy / iN_trdy   : per-input valid / accept
//   iN_data_type        : per-input payload
//   o0_irdy / o0_trdy   : merged valid / downstream accept
//   o0_data_type        : payload of the selected input
//   sel                 : currently selected input index
//   starve              : per-input wait counter saturated
//   xfer_cnt            : completed output transfers (wraps)
module merge4_rr_arb
  import merge_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_irdy,
  input  logic              i1_irdy,
  input  logic              i2_irdy,
  input  logic              i3_irdy,
  output logic              i0_trdy,
  output logic              i1_trdy,
  output logic              i2_trdy,
  output logic              i3_trdy,
  input  logic [DATA_W-1:0] i0_data_type,
  input  logic [DATA_W-1:0] i1_data_type,
  input  logic [DATA_W-1:0] i2_data_type,
  input  logic [DATA_W-1:0] i3_data_type,
  output logic              o0_irdy,
  input  logic              o0_trdy,
  output logic [DATA_W-1:0] o0_data_type,
  output logic [1:0]        sel,
  output logic [3:0]        starve,
  output logic [15:0]       xfer_cnt
);

  logic [1:0]        r_ptr;
  logic              r_lock;
  logic [1:0]        r_lock_idx;
  logic [CW-1:0]     r_wait [N_IN];
  logic [15:0]       r_xfer;

  logic [N_IN-1:0]   w_irdy;
  logic [N_IN-1:0]   w_trdy;
  logic [DATA_W-1:0] w_data [N_IN];
  logic [1:0]        w_pick_idx;
  logic              w_pick_any;
  logic              w_xfer;
  logic              w_stall;
  logic              w_viol;

  assign w_irdy    = {i3_irdy, i2_irdy, i1_irdy, i0_irdy};
  assign w_data[0] = i0_data_type;
  assign w_data[1] = i1_data_type;
  assign w_data[2] = i2_data_type;
  assign w_data[3] = i3_data_type;

  rr_pick4 u_pick (
    .i_req (w_irdy),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Selection is forced to 0 while in reset so nothing stale is presented.
  assign sel          = !rst ? 2'd0 : (r_lock ? r_lock_idx : w_pick_idx);
  assign o0_irdy      = w_pick_any & rst;
  assign o0_data_type = w_data[sel];

  always_comb begin
    w_trdy = '0;
    for (int k = 0; k < N_IN; k++)
      w_trdy[k] = (sel == 2'(k)) & w_irdy[k] & o0_trdy & rst;
  end

  assign {i3_trdy, i2_trdy, i1_trdy, i0_trdy} = w_trdy;

  // A transfer is an actual accept; when a locked input has dropped irdy
  // the output may still look valid but nothing is handed over.
  assign w_xfer  = |w_trdy;
  assign w_stall = o0_irdy & ~o0_trdy;
  assign w_viol  = r_lock & ~w_irdy[r_lock_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr      <= 2'd0;
      r_lock     <= 1'b0;
      r_lock_idx <= 2'd0;
      r_xfer     <= 16'd0;
    end else if (w_viol) begin
      r_lock <= 1'b0;
    end else if (w_xfer) begin
      r_ptr  <= sel + 2'd1;
      r_lock <= 1'b0;
      r_xfer <= r_xfer + 16'd1;
    end else if (w_stall) begin
      r_lock     <= 1'b1;
      r_lock_idx <= sel;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_IN; k++) begin
      if (!rst) begin
        r_wait[k] <= '0;
      end else if (w_irdy[k] && !w_trdy[k]) begin
        if (r_wait[k] != '1) r_wait[k] <= r_wait[k] + CW'(1);
      end else begin
        r_wait[k] <= '0;
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int k = 0; k < N_IN; k++)
      starve[k] = rst & (r_wait[k] == '1);
  end

  assign xfer_cnt = r_xfer;

endmodule

// File: tb/tb_merge4_rr_arb.sv
module tb_merge4_rr_arb;
  localparam int DATA_W = 2;
  localparam int CW     = 4;
  localparam int WMAX   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        irdy;
  logic [DATA_W-1:0] dat [4];
  logic              o_trdy;
  logic              t0, t1, t2, t3;
  logic [3:0]        trdy;
  logic              o_irdy;
  logic [DATA_W-1:0] o_data;
  logic [1:0]        sel;
  logic [3:0]        starve;
  logic [15:0]       xfer_cnt;

  always #5 clk = ~clk;
  assign trdy = {t3, t2, t1, t0};

  merge4_rr_arb #(.DATA_W(DATA_W), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i0_irdy      (irdy[0]),
    .i1_irdy      (irdy[1]),
    .i2_irdy      (irdy[2]),
    .i3_irdy      (irdy[3]),
    .i0_trdy      (t0),
    .i1_trdy      (t1),
    .i2_trdy      (t2),
    .i3_trdy      (t3),
    .i0_data_type (dat[0]),
    .i1_data_type (dat[1]),
    .i2_data_type (dat[2]),
    .i3_data_type (dat[3]),
    .o0_irdy      (o_irdy),
    .o0_trdy      (o_trdy),
    .o0_data_type (o_data),
    .sel          (sel),
    .starve       (starve),
    .xfer_cnt     (xfer_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: arbitration state described by its rules.
  int          m_ptr, m_lidx, m_xfer;
  bit          m_lock;
  int          m_wait [4];
  int          m_wx   [4];
  int          e_sel;
  bit          e_oirdy;
  logic [3:0]  e_trdy;
  bit          p_stall;
  int          p_sel;
  logic [DATA_W-1:0] p_data;

  function automatic int model_sel();
    if (!rst) return 0;
    if (m_lock) return m_lidx;
    for (int d = 0; d < 4; d++)
      if (irdy[(m_ptr + d) % 4]) return (m_ptr + d) % 4;
    return m_ptr;
  endfunction

  task automatic check_phase();
    logic [3:0] es;
    @(negedge clk);
    e_sel   = model_sel();
    e_oirdy = rst && (irdy != 4'b0);
    e_trdy  = '0;
    if (rst && o_trdy && irdy[e_sel]) e_trdy[e_sel] = 1'b1;
    es = '0;
    for (int k = 0; k < 4; k++) es[k] = rst && (m_wait[k] == WMAX);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("o_irdy", 32'(o_irdy), 32'(e_oirdy));
    chk("trdy", 32'(trdy), 32'(e_trdy));
    chk("onehot", 32'($countones(trdy) <= 1), 32'd1);
    chk("data", 32'(o_data), 32'(dat[e_sel]));
    chk("starve", 32'(starve), 32'(es));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    if (rst && p_stall && irdy[p_sel]) chk("stable", 32'(o_data), 32'(p_data));
  endtask

  task automatic edge_phase();
    bit xf;
    @(posedge clk);
    xf = (e_trdy != 4'b0);
    p_stall = rst && e_oirdy && !o_trdy && irdy[e_sel];
    p_sel   = e_sel;
    p_data  = dat[e_sel];
    if (!rst) begin
      m_ptr = 0; m_lock = 0; m_lidx = 0; m_xfer = 0;
      for (int k = 0; k < 4; k++) begin m_wait[k] = 0; m_wx[k] = 0; end
    end else begin
      if (m_lock && !irdy[m_lidx]) m_lock = 0;
      else if (xf) begin
        m_ptr = (e_sel + 1) % 4; m_lock = 0; m_xfer = (m_xfer + 1) % 65536;
      end else if (e_oirdy && !o_trdy) begin
        m_lock = 1; m_lidx = e_sel;
      end
      for (int k = 0; k < 4; k++) begin
        if (irdy[k] && !e_trdy[k]) m_wait[k] = (m_wait[k] < WMAX) ? m_wait[k] + 1 : WMAX;
        else m_wait[k] = 0;
        if (!irdy[k] || e_trdy[k]) m_wx[k] = 0;
        else if (xf) begin
          m_wx[k]++;
          chk("fair", 32'(m_wx[k] <= 3), 32'd1);
        end
      end
    end
    #1;
  endtask

  task automatic step();
    check_phase();
    edge_phase();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; irdy = 4'b1011; o_trdy = 1'b1;
    for (int k = 0; k < 4; k++) dat[k] = DATA_W'(k);
    m_ptr = 0; m_lock = 0; m_lidx = 0; m_xfer = 0; p_stall = 0; p_sel = 0; p_data = '0;
    for (int k = 0; k < 4; k++) begin m_wait[k] = 0; m_wx[k] = 0; end

    // Reset state: nothing granted, selection and starve held at 0.
    for (int c = 0; c < 2; c++) begin
      check_phase();
      chk("rst_trdy", 32'(trdy), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      edge_phase();
    end
    rst = 1'b1; irdy = 4'b0000;
    check_phase();
    chk("post_rst_sel", 32'(sel), 32'd0);
    chk("post_rst_starve", 32'(starve), 32'd0);
    edge_phase();

    // All inputs valid, downstream ready: strict rotation.
    irdy = 4'b1111; o_trdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check_phase();
      chk("rot_sel", 32'(sel), 32'(c % 4));
      chk("rot_data", 32'(o_data), 32'(c % 4));
      edge_phase();
    end
    check_phase();
    chk("rot_xfer", 32'(xfer_cnt), 32'd8);
    edge_phase();

    // Stall on i2, i0 arrives while locked.
    do_reset();
    irdy = 4'b0100; o_trdy = 1'b0; dat[2] = 2'd2; dat[0] = 2'd1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) irdy = 4'b0101;
      check_phase();
      chk("lock_sel", 32'(sel), 32'd2);
      chk("lock_data", 32'(o_data), 32'd2);
      edge_phase();
    end
    o_trdy = 1'b1;
    check_phase();
    chk("lock_trdy", 32'(trdy), 32'b0100);
    edge_phase();
    irdy = 4'b1001; o_trdy = 1'b0;
    check_phase();
    chk("ptr3_sel", 32'(sel), 32'd3);
    edge_phase();

    // Starvation on i1.
    do_reset();
    irdy = 4'b0010; o_trdy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check_phase();
      chk("starve1", 32'(starve[1]), 32'(c >= 15));
      edge_phase();
    end
    o_trdy = 1'b1;
    check_phase();
    chk("starve_xfer", 32'(t1), 32'd1);
    edge_phase();
    o_trdy = 1'b0;
    check_phase();
    chk("starve_clr", 32'(starve[1]), 32'd0);
    edge_phase();

    // Reset while locked on i3.
    do_reset();
    irdy = 4'b1000; o_trdy = 1'b1;
    step(); step();
    o_trdy = 1'b0;
    step(); step();
    rst = 1'b0; o_trdy = 1'b1;
    check_phase();
    chk("rstlock_trdy", 32'(trdy), 32'd0);
    chk("rstlock_oirdy", 32'(o_irdy), 32'd0);
    edge_phase();
    rst = 1'b1; irdy = 4'b1001; o_trdy = 1'b0;
    check_phase();
    chk("rstlock_sel", 32'(sel), 32'd0);
    chk("rstlock_xfer", 32'(xfer_cnt), 32'd0);
    edge_phase();

    // Locked input drops irdy: no grant, lock released.
    do_reset();
    irdy = 4'b0100; o_trdy = 1'b0;
    step();
    irdy = 4'b0001; o_trdy = 1'b1;
    check_phase();
    chk("viol_trdy", 32'(trdy), 32'd0);
    edge_phase();
    check_phase();
    chk("viol_sel", 32'(sel), 32'd0);
    edge_phase();

    // Transfer counter wrap.
    do_reset();
    irdy = 4'b0001; o_trdy = 1'b1;
    for (int c = 0; c < 65535; c++) step();
    check_phase();
    chk("wrap_pre", 32'(xfer_cnt), 32'hFFFF);
    edge_phase();
    check_phase();
    chk("wrap_post", 32'(xfer_cnt), 32'h0000);
    edge_phase();

    // Random traffic with well-behaved requesters (hold until accepted).
    do_reset();
    irdy = 4'b0000; o_trdy = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (!(irdy[k] && !e_trdy[k])) begin
          irdy[k] = ($urandom_range(9) < 6);
          dat[k]  = DATA_W'($urandom);
        end
      end
      o_trdy = ($urandom_range(3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
